// File: rtl/fp_noncomp_pipe_pkg.sv
// Shared types for the FP non-computational unit: op encodings, op modifiers,
// exception flags, classify mask and the canonical NaN helper.
package fp_noncomp_pipe_pkg;

   typedef enum logic [4:0] {
      FP_SGNJ     = 5'd6,
      FP_MINMAX   = 5'd7,
      FP_CMP      = 5'd8,
      FP_CLASSIFY = 5'd9
   } fpnew_op_e;

   typedef enum logic [1:0] {
      SGNJ_J = 2'd0,
      SGNJ_N = 2'd1,
      SGNJ_X = 2'd2
   } fpnew_op_mod_e;

   typedef enum logic [1:0] {
      CMP_LE = 2'd0,
      CMP_LT = 2'd1,
      CMP_EQ = 2'd2
   } fp_cmp_mod_e;

   typedef enum logic [1:0] {
      MM_MIN = 2'd0,
      MM_MAX = 2'd1
   } fp_minmax_mod_e;

   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } fpnew_exc_flags_t;

   typedef logic [9:0] fp_classmask_t;

   // Quiet NaN with sign 0, exponent all-ones, only the mantissa MSB set.
   function automatic logic [63:0] canonical_nan(input int unsigned ew, input int unsigned mw);
      logic [63:0] n;
      n = ((64'd1 << ew) - 64'd1) << mw;
      if (mw > 0) n = n | (64'd1 << (mw - 1));
      return n;
   endfunction

endpackage

// File: rtl/fp_noncomp_pipe_classifier.sv
// Combinational operand classifier: splits one FP value into its IEEE-754 class.
module fp_classifier #(
   parameter  int unsigned ExpWidth = 8,
   parameter  int unsigned ManWidth = 23,
   localparam int unsigned FpWidth  = 1 + ExpWidth + ManWidth
) (
   input  logic [FpWidth-1:0] i_op,
   output logic               o_sign,
   output logic               o_is_zero,
   output logic               o_is_inf,
   output logic               o_is_nan,
   output logic               o_is_snan,
   output logic               o_is_qnan,
   output logic               o_is_subnormal,
   output logic               o_is_normal
);

   logic [ExpWidth-1:0] w_exp;
   logic [ManWidth-1:0] w_man;
   logic                w_exp_ones;
   logic                w_exp_zero;
   logic                w_man_zero;

   assign w_exp      = i_op[ManWidth +: ExpWidth];
   assign w_man      = i_op[ManWidth-1:0];
   assign w_exp_ones = &w_exp;
   assign w_exp_zero = ~|w_exp;
   assign w_man_zero = ~|w_man;

   assign o_sign         = i_op[FpWidth-1];
   assign o_is_zero      = w_exp_zero & w_man_zero;
   assign o_is_subnormal = w_exp_zero & ~w_man_zero;
   assign o_is_inf       = w_exp_ones & w_man_zero;
   assign o_is_nan       = w_exp_ones & ~w_man_zero;
   assign o_is_snan      = o_is_nan & ~w_man[ManWidth-1];
   assign o_is_qnan      = o_is_nan & w_man[ManWidth-1];
   assign o_is_normal    = ~w_exp_ones & ~w_exp_zero;

endmodule

// File: rtl/fp_noncomp_pipe.sv
// Pipelined FP non-computational unit (SGNJ / MINMAX / CMP / CLASSIFY) with an
// elastic valid/ready pipeline of NumPipeRegs stages after the compute logic.
module fp_noncomp_pipe
   import fp_noncomp_pipe_pkg::*;
#(
   parameter  int unsigned ExpWidth    = 8,
   parameter  int unsigned ManWidth    = 23,
   parameter  int unsigned NumPipeRegs = 1,
   parameter  int unsigned TagWidth    = 4,
   localparam int unsigned FpWidth     = 1 + ExpWidth + ManWidth
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [FpWidth-1:0]  op_a_i,
   input  logic [FpWidth-1:0]  op_b_i,
   input  logic [4:0]          op_i,
   input  logic [1:0]          op_mod_i,
   input  logic [TagWidth-1:0] tag_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic                flush_i,
   output logic [FpWidth-1:0]  result_o,
   output logic                is_int_o,
   output logic [4:0]          status_o,
   output logic [TagWidth-1:0] tag_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                busy_o
);

   localparam int unsigned DataW = FpWidth + 1 + 5 + TagWidth;
   localparam logic [FpWidth-1:0] CanonNan = FpWidth'(canonical_nan(ExpWidth, ManWidth));

   logic w_a_sign, w_a_zero, w_a_inf, w_a_nan, w_a_snan, w_a_qnan, w_a_sub, w_a_norm;
   logic w_b_sign, w_b_zero, w_b_inf, w_b_nan, w_b_snan, w_b_qnan, w_b_sub, w_b_norm;
   logic w_unused_b;

   fp_classifier #(.ExpWidth(ExpWidth), .ManWidth(ManWidth)) u_class_a (
      .i_op(op_a_i), .o_sign(w_a_sign), .o_is_zero(w_a_zero), .o_is_inf(w_a_inf),
      .o_is_nan(w_a_nan), .o_is_snan(w_a_snan), .o_is_qnan(w_a_qnan),
      .o_is_subnormal(w_a_sub), .o_is_normal(w_a_norm)
   );

   fp_classifier #(.ExpWidth(ExpWidth), .ManWidth(ManWidth)) u_class_b (
      .i_op(op_b_i), .o_sign(w_b_sign), .o_is_zero(w_b_zero), .o_is_inf(w_b_inf),
      .o_is_nan(w_b_nan), .o_is_snan(w_b_snan), .o_is_qnan(w_b_qnan),
      .o_is_subnormal(w_b_sub), .o_is_normal(w_b_norm)
   );

   assign w_unused_b = ^{w_b_inf, w_b_qnan, w_b_sub, w_b_norm};

   // Ordering helpers: sign-magnitude compare, -0 sorts below +0 for MINMAX.
   logic w_mag_lt, w_mag_eq, w_a_lt_b, w_both_zero, w_eq, w_lt_cmp, w_any_nan, w_any_snan;
   assign w_mag_lt    = op_a_i[FpWidth-2:0] < op_b_i[FpWidth-2:0];
   assign w_mag_eq    = op_a_i[FpWidth-2:0] == op_b_i[FpWidth-2:0];
   assign w_a_lt_b    = (w_a_sign != w_b_sign) ? w_a_sign
                      : (w_a_sign ? ~(w_mag_lt | w_mag_eq) : w_mag_lt);
   assign w_both_zero = w_a_zero & w_b_zero;
   assign w_eq        = (op_a_i == op_b_i) | w_both_zero;
   assign w_lt_cmp    = w_a_lt_b & ~w_both_zero;
   assign w_any_nan   = w_a_nan | w_b_nan;
   assign w_any_snan  = w_a_snan | w_b_snan;

   fp_classmask_t w_class;
   assign w_class = {w_a_qnan, w_a_snan,
                     ~w_a_sign & w_a_inf, ~w_a_sign & w_a_norm, ~w_a_sign & w_a_sub, ~w_a_sign & w_a_zero,
                      w_a_sign & w_a_zero,  w_a_sign & w_a_sub,  w_a_sign & w_a_norm,  w_a_sign & w_a_inf};

   logic [FpWidth-1:0] w_res;
   logic               w_is_int;
   fpnew_exc_flags_t   w_status;

   // Operation result and flags, computed ahead of the first pipe stage.
   always_comb begin
      w_res    = '0;
      w_is_int = 1'b0;
      w_status = '0;
      case (op_i)
         FP_SGNJ: begin
            w_res = op_a_i;
            case (op_mod_i)
               SGNJ_N:  w_res[FpWidth-1] = ~w_b_sign;
               SGNJ_X:  w_res[FpWidth-1] = w_a_sign ^ w_b_sign;
               default: w_res[FpWidth-1] = w_b_sign;
            endcase
         end
         FP_MINMAX: begin
            w_status.NV = w_any_snan;
            if (w_a_nan && w_b_nan)     w_res = CanonNan;
            else if (w_a_nan)           w_res = op_b_i;
            else if (w_b_nan)           w_res = op_a_i;
            else if (op_mod_i == MM_MAX) w_res = w_a_lt_b ? op_b_i : op_a_i;
            else                        w_res = w_a_lt_b ? op_a_i : op_b_i;
         end
         FP_CMP: begin
            w_is_int = 1'b1;
            case (op_mod_i)
               CMP_EQ: begin
                  w_status.NV = w_any_snan;
                  w_res[0]    = ~w_any_nan & w_eq;
               end
               CMP_LT: begin
                  w_status.NV = w_any_nan;
                  w_res[0]    = ~w_any_nan & w_lt_cmp;
               end
               CMP_LE: begin
                  w_status.NV = w_any_nan;
                  w_res[0]    = ~w_any_nan & (w_lt_cmp | w_eq);
               end
               default: ;
            endcase
         end
         FP_CLASSIFY: begin
            w_is_int   = 1'b1;
            w_res[9:0] = w_class;
         end
         default: w_status.NV = 1'b1;
      endcase
   end

   logic [DataW-1:0] w_in_data;
   logic [DataW-1:0] w_out_data;
   assign w_in_data = {w_res, w_is_int, w_status, tag_i};
   assign {result_o, is_int_o, status_o, tag_o} = w_out_data;

   if (NumPipeRegs == 0) begin : g_comb
      assign in_ready_o  = out_ready_i;
      assign out_valid_o = in_valid_i & ~flush_i;
      assign w_out_data  = w_in_data;
      assign busy_o      = 1'b0;
   end else begin : g_pipe
      logic [NumPipeRegs-1:0] w_valid_vec;
      logic [NumPipeRegs-1:0] w_load;

      for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
         logic             r_valid;
         logic [DataW-1:0] r_data;
         logic             w_up_valid;
         logic [DataW-1:0] w_up_data;

         // Stage k can take new data if it or any stage after it has a bubble,
         // or the output side is draining; closed form avoids a ready chain.
         assign w_load[k]      = out_ready_i | ~&w_valid_vec[NumPipeRegs-1:k];
         assign w_valid_vec[k] = r_valid;

         if (k == 0) begin : g_first
            assign w_up_valid = in_valid_i;
            assign w_up_data  = w_in_data;
         end else begin : g_next
            assign w_up_valid = g_stage[k-1].r_valid;
            assign w_up_data  = g_stage[k-1].r_data;
         end

         // Stage register: flush kills the valid, stall holds the payload.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid <= 1'b0;
               r_data  <= '0;
            end else if (flush_i) begin
               r_valid <= 1'b0;
            end else if (w_load[k]) begin
               r_valid <= w_up_valid;
               if (w_up_valid) r_data <= w_up_data;
            end
         end
      end

      assign in_ready_o  = w_load[0];
      assign out_valid_o = w_valid_vec[NumPipeRegs-1];
      assign w_out_data  = g_stage[NumPipeRegs-1].r_data;
      assign busy_o      = |w_valid_vec;
   end

endmodule

// File: tb/tb_fp_noncomp_pipe.sv
// Scoreboard bench for fp_noncomp_pipe: three instances (FP32 1-stage,
// FP32 3-stage, FP16 combinational) share one driver and one monitor via sel.
module tb_fp_noncomp_pipe;
   import fp_noncomp_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] op_a = '0, op_b = '0;
   logic [4:0]  op = '0;
   logic [1:0]  md = '0;
   logic [3:0]  tg = '0;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready;
   int          sel = 0;
   int          ready_mode = 0;

   logic [31:0] r1, r3;  logic [15:0] r16;
   logic        i1, i3, i16, v1, v3, v16, b1, b3, b16, rdy1, rdy3, rdy16;
   logic [4:0]  s1, s3, s16;
   logic [3:0]  t1, t3, t16;

   fp_noncomp_pipe #(.ExpWidth(8), .ManWidth(23), .NumPipeRegs(1), .TagWidth(4)) u1 (
      .clk(clk), .rst_n(rst_n), .op_a_i(op_a), .op_b_i(op_b), .op_i(op), .op_mod_i(md),
      .tag_i(tg), .in_valid_i(in_valid && sel == 0), .in_ready_o(rdy1), .flush_i(flush),
      .result_o(r1), .is_int_o(i1), .status_o(s1), .tag_o(t1), .out_valid_o(v1),
      .out_ready_i(out_ready), .busy_o(b1));

   fp_noncomp_pipe #(.ExpWidth(8), .ManWidth(23), .NumPipeRegs(3), .TagWidth(4)) u3 (
      .clk(clk), .rst_n(rst_n), .op_a_i(op_a), .op_b_i(op_b), .op_i(op), .op_mod_i(md),
      .tag_i(tg), .in_valid_i(in_valid && sel == 1), .in_ready_o(rdy3), .flush_i(flush),
      .result_o(r3), .is_int_o(i3), .status_o(s3), .tag_o(t3), .out_valid_o(v3),
      .out_ready_i(out_ready), .busy_o(b3));

   fp_noncomp_pipe #(.ExpWidth(5), .ManWidth(10), .NumPipeRegs(0), .TagWidth(4)) u16 (
      .clk(clk), .rst_n(rst_n), .op_a_i(op_a[15:0]), .op_b_i(op_b[15:0]), .op_i(op), .op_mod_i(md),
      .tag_i(tg), .in_valid_i(in_valid && sel == 2), .in_ready_o(rdy16), .flush_i(flush),
      .result_o(r16), .is_int_o(i16), .status_o(s16), .tag_o(t16), .out_valid_o(v16),
      .out_ready_i(out_ready), .busy_o(b16));

   logic [31:0] m_res;  logic m_int, m_valid, m_rdy;  logic [4:0] m_st;  logic [3:0] m_tag;
   always_comb begin
      m_res = r1; m_int = i1; m_st = s1; m_tag = t1; m_valid = v1; m_rdy = rdy1;
      if (sel == 1) begin
         m_res = r3; m_int = i3; m_st = s3; m_tag = t3; m_valid = v3; m_rdy = rdy3;
      end else if (sel == 2) begin
         m_res = {16'h0, r16}; m_int = i16; m_st = s16; m_tag = t16; m_valid = v16; m_rdy = rdy16;
      end
   end

   typedef struct packed {
      logic [31:0] res;
      logic        is_int;
      logic [4:0]  st;
      logic [3:0]  tag;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   localparam logic [4:0] NV = 5'b10000;

   // Output-ready pattern generator.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: every output handshake pops and compares one expected entry.
   initial begin
      exp_t e, got;
      forever begin
         @(negedge clk); #1;
         if (m_valid && out_ready) begin
            got = '{res: m_res, is_int: m_int, st: m_st, tag: m_tag};
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got res=%h int=%b st=%b tag=%0d, required no output",
                        m_res, m_int, m_st, m_tag);
            end else begin
               e = q.pop_front();
               if (got !== e)
                  $display("FAIL out_tag%0d: got res=%h int=%b st=%b tag=%0d, required res=%h int=%b st=%b tag=%0d",
                           e.tag, m_res, m_int, m_st, m_tag, e.res, e.is_int, e.st, e.tag);
               if (got !== e) errors++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, expv);
      end
   endtask

   // Offer one op from posedge+1; push its expectation when it is accepted.
   task automatic issue(input logic [4:0] o, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t, input logic [31:0] er,
                        input logic ei, input logic [4:0] es);
      bit ok;
      ok = 1'b0;
      op = o; md = m; op_a = a; op_b = b; tg = t; in_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (m_rdy) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (ok) q.push_back('{res: er, is_int: ei, st: es, tag: t});
      else begin
         checks++; errors++;
         $display("FAIL issue_tag%0d: got in_ready=0 for 200 cycles, required acceptance", t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge clk);
      chk(nm, 32'(q.size()), 32'd0);
      q.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_u1_valid", 32'(v1), 32'd0);
      chk("reset_u1_busy",  32'(b1), 32'd0);
      chk("reset_u1_outs",  {r1[25:0], i1, s1}, 32'd0);
      chk("reset_u1_tag",   32'(t1), 32'd0);
      chk("reset_u3_valid", 32'({v3, b3}), 32'd0);
      chk("reset_u3_outs",  {r3[21:0], i3, s3, t3}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // FP32, one stage
      sel = 0;
      issue(FP_SGNJ, SGNJ_N, 32'h3F800000, 32'h3F800000, 4'd1, 32'hBF800000, 1'b0, 5'd0);
      chk("sgnjn_latency_valid", 32'(v1), 32'd1);
      issue(FP_MINMAX, MM_MIN, 32'h80000000, 32'h00000000, 4'd2,  32'h80000000, 1'b0, 5'd0);
      issue(FP_MINMAX, MM_MAX, 32'h7FC00000, 32'h40000000, 4'd3,  32'h40000000, 1'b0, 5'd0);
      issue(FP_MINMAX, MM_MAX, 32'h7F800001, 32'h7F800001, 4'd4,  32'h7FC00000, 1'b0, NV);
      issue(FP_MINMAX, MM_MIN, 32'h7F800001, 32'h3F800000, 4'd5,  32'h3F800000, 1'b0, NV);
      issue(FP_CMP,    CMP_LT, 32'h7FC00000, 32'h3F800000, 4'd6,  32'h0,        1'b1, NV);
      issue(FP_CMP,    CMP_EQ, 32'h7FC00000, 32'h3F800000, 4'd7,  32'h0,        1'b1, 5'd0);
      issue(FP_CMP,    CMP_EQ, 32'h80000000, 32'h00000000, 4'd8,  32'h1,        1'b1, 5'd0);
      issue(FP_CMP,    CMP_LT, 32'h80000000, 32'h00000000, 4'd9,  32'h0,        1'b1, 5'd0);
      issue(FP_CMP,    CMP_EQ, 32'h7F800001, 32'h3F800000, 4'd10, 32'h0,        1'b1, NV);
      issue(FP_CLASSIFY, 2'd0, 32'h00000001, 32'h0,        4'd11, 32'h020,      1'b1, 5'd0);
      issue(FP_CLASSIFY, 2'd0, 32'hFF800000, 32'h0,        4'd12, 32'h001,      1'b1, 5'd0);
      issue(FP_CLASSIFY, 2'd0, 32'h7F800001, 32'h0,        4'd13, 32'h100,      1'b1, 5'd0);
      issue(FP_CLASSIFY, 2'd0, 32'h7FC00000, 32'h0,        4'd14, 32'h200,      1'b1, 5'd0);
      issue(FP_CLASSIFY, 2'd0, 32'h80000000, 32'h0,        4'd15, 32'h008,      1'b1, 5'd0);
      issue(5'd3,        2'd0, 32'h3F800000, 32'h3F800000, 4'd0,  32'h0,        1'b0, NV);
      issue(FP_CLASSIFY, 2'd0, 32'h3F800000, 32'h0,        4'd1,  32'h040,      1'b1, 5'd0);
      drain("drain_fp32_p1");

      // FP32, three stages, random output stalls
      sel = 1;
      ready_mode = 1;
      issue(FP_SGNJ,   SGNJ_J, 32'h3F800000, 32'h80000000, 4'd0, 32'hBF800000, 1'b0, 5'd0);
      issue(FP_SGNJ,   SGNJ_X, 32'hBF800000, 32'hBF800000, 4'd1, 32'h3F800000, 1'b0, 5'd0);
      issue(FP_SGNJ,   SGNJ_X, 32'h7F800001, 32'h80000000, 4'd2, 32'hFF800001, 1'b0, 5'd0);
      issue(FP_MINMAX, MM_MIN, 32'hC0000000, 32'h3F800000, 4'd3, 32'hC0000000, 1'b0, 5'd0);
      issue(FP_MINMAX, MM_MAX, 32'hC0000000, 32'hC0400000, 4'd4, 32'hC0000000, 1'b0, 5'd0);
      issue(FP_CMP,    CMP_LT, 32'hBF800000, 32'h3F800000, 4'd5, 32'h1,        1'b1, 5'd0);
      issue(FP_CMP,    CMP_LE, 32'h3F800000, 32'h3F800000, 4'd6, 32'h1,        1'b1, 5'd0);
      issue(FP_CLASSIFY, 2'd0, 32'h807FFFFF, 32'h0,        4'd7, 32'h004,      1'b1, 5'd0);
      drain("drain_stream_p3");
      ready_mode = 0;
      @(posedge clk); #1;

      // Flush with two ops in flight and a third offered in the flush cycle
      issue(FP_SGNJ, SGNJ_J, 32'h3F800000, 32'h0, 4'd8, 32'h3F800000, 1'b0, 5'd0);
      issue(FP_SGNJ, SGNJ_J, 32'h40000000, 32'h0, 4'd9, 32'h40000000, 1'b0, 5'd0);
      op = FP_SGNJ; md = SGNJ_J; op_a = 32'h40400000; tg = 4'd14; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_busy",  32'(b3), 32'd0);
      chk("flush_valid", 32'(v3), 32'd0);
      q.delete();
      repeat (6) @(posedge clk);
      #1;
      chk("flush_stays_idle", 32'({v3, b3}), 32'd0);

      // Asynchronous reset mid-stream
      issue(FP_SGNJ, SGNJ_J, 32'h3F800000, 32'h0, 4'd10, 32'h3F800000, 1'b0, 5'd0);
      issue(FP_SGNJ, SGNJ_J, 32'h40000000, 32'h0, 4'd11, 32'h40000000, 1'b0, 5'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy",  32'(b3), 32'd0);
      chk("rst_mid_valid", 32'(v3), 32'd0);
      chk("rst_mid_result", r3, 32'd0);
      q.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(FP_SGNJ, SGNJ_N, 32'h3F800000, 32'h3F800000, 4'd12, 32'hBF800000, 1'b0, 5'd0);
      drain("drain_after_reset");

      // FP16, combinational
      sel = 2;
      @(posedge clk); #1;
      issue(FP_MINMAX, MM_MAX, 32'h0000FC00, 32'h00007E00, 4'd3, 32'h0000FC00, 1'b0, 5'd0);
      issue(FP_CLASSIFY, 2'd0, 32'h00000400, 32'h0,        4'd4, 32'h00000040, 1'b1, 5'd0);
      issue(FP_MINMAX, MM_MAX, 32'h00007C01, 32'h00007C01, 4'd5, 32'h00007E00, 1'b0, NV);
      drain("drain_fp16_p0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, required completion before 200000");
      $fatal(1);
   end

endmodule
